// File: rtl/iir_mac_sched.sv
// Second-order IIR section that runs five taps through one shared multiplier.
// Ports: clk, rst_n (async, active-high), in_* sample in, out_* sample out, cfg_* coefficient writes.
module iir_mac_sched #(
    parameter int DW   = 12,
    parameter int CW   = 12,
    parameter int FRAC = 10,
    parameter int AW   = 28
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          sat_flag,
    output logic          busy,
    input  logic          flush,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [CW-1:0] cfg_data,
    output logic          cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    localparam logic [CW-1:0] B0_RST = CW'(1024);
    localparam logic [CW-1:0] A1_RST = CW'(1911);
    localparam logic [CW-1:0] A2_RST = CW'(-986);

    localparam logic [AW-1:0] HALF =
        {{(AW-1){1'b0}}, 1'b1} << (FRAC-1);
    localparam logic signed [AW-1:0] YMAX =
        {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] YMIN =
        {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_t state_q, state_d;
    logic [2:0] tap_q, tap_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [DW-1:0] x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
    logic signed [DW-1:0] y1_q, y1_d, y2_q, y2_d;
    logic signed [CW-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic signed [CW-1:0] a1_q, a1_d, a2_q, a2_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic out_valid_q, out_valid_d;
    logic sat_q, sat_d;
    logic cfg_err_q, cfg_err_d;

    logic hs, cfg_ok, clamp;
    logic signed [CW-1:0] mul_c;
    logic signed [DW-1:0] mul_s, y_c;
    logic signed [DW+CW-1:0] prod;
    logic signed [AW-1:0] prod_ext, rnd, shr;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_q;
    assign cfg_err   = cfg_err_q;

    assign hs     = in_valid & in_ready;
    assign cfg_ok = cfg_we & (state_q == S_IDLE) & ~hs;

    always_comb begin
        mul_c = '0;
        mul_s = '0;
        unique case (tap_q)
            3'd0: begin mul_c = b0_q; mul_s = x0_q; end
            3'd1: begin mul_c = b1_q; mul_s = x1_q; end
            3'd2: begin mul_c = b2_q; mul_s = x2_q; end
            3'd3: begin mul_c = a1_q; mul_s = y1_q; end
            3'd4: begin mul_c = a2_q; mul_s = y2_q; end
            default: begin mul_c = '0; mul_s = '0; end
        endcase
    end

    assign prod     = mul_c * mul_s;
    assign prod_ext = {{(AW-DW-CW){prod[DW+CW-1]}}, prod};

    // Round half up, then floor via arithmetic shift.
    assign rnd = acc_q + $signed(HALF);
    assign shr = rnd >>> FRAC;

    always_comb begin
        clamp = 1'b0;
        y_c   = shr[DW-1:0];
        if (shr > YMAX) begin
            clamp = 1'b1;
            y_c   = YMAX[DW-1:0];
        end else if (shr < YMIN) begin
            clamp = 1'b1;
            y_c   = YMIN[DW-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        a1_d        = a1_q;
        a2_d        = a2_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        sat_d       = 1'b0;
        cfg_err_d   = cfg_we & ~cfg_ok & (cfg_addr < 3'd5);

        if (cfg_ok) begin
            case (cfg_addr)
                3'd0: b0_d = cfg_data;
                3'd1: b1_d = cfg_data;
                3'd2: b2_d = cfg_data;
                3'd3: a1_d = cfg_data;
                3'd4: a2_d = cfg_data;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    x0_d    = in_data;
                    acc_d   = '0;
                    tap_d   = '0;
                    state_d = S_MAC;
                end else if (flush) begin
                    x1_d = '0;
                    x2_d = '0;
                    y1_d = '0;
                    y2_d = '0;
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod_ext;
                tap_d = tap_q + 3'd1;
                if (tap_q == 3'd4) state_d = S_OUT;
            end
            S_OUT: begin
                out_data_d  = y_c;
                out_valid_d = 1'b1;
                sat_d       = clamp;
                x2_d        = x1_q;
                x1_d        = x0_q;
                y2_d        = y1_q;
                y1_d        = y_c;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            tap_q       <= '0;
            acc_q       <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            b0_q        <= B0_RST;
            b1_q        <= '0;
            b2_q        <= '0;
            a1_q        <= A1_RST;
            a2_q        <= A2_RST;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_iir_mac_sched.sv
// Scoreboard bench for iir_mac_sched.
// A reference model predicts each output at handshake time.
module tb_iir_mac_sched;

    localparam int DW = 12;
    localparam int CW = 12;

    logic clk, rst_n;
    logic in_valid, in_ready, out_valid, sat_flag, busy;
    logic [DW-1:0] in_data;
    logic signed [DW-1:0] out_data;
    logic flush, cfg_we, cfg_err;
    logic [2:0] cfg_addr;
    logic [CW-1:0] cfg_data;

    iir_mac_sched dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .sat_flag(sat_flag),
        .busy(busy), .flush(flush),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_err(cfg_err)
    );

    typedef struct {
        int d;
        int s;
        int c;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mc[5];
    int mx1, mx2, my1, my2;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mc[0] = 1024; mc[1] = 0; mc[2] = 0;
        mc[3] = 1911; mc[4] = -986;
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
    endtask

    task automatic model_push(input int x);
        longint acc, r;
        exp_t e;
        acc = longint'(mc[0]) * x + longint'(mc[1]) * mx1
            + longint'(mc[2]) * mx2 + longint'(mc[3]) * my1
            + longint'(mc[4]) * my2;
        r = (acc + 512) >>> 10;
        e.s = 0;
        if (r > 2047) begin r = 2047; e.s = 1; end
        else if (r < -2048) begin r = -2048; e.s = 1; end
        e.d = int'(r);
        e.c = cyc;
        mx2 = mx1; mx1 = x;
        my2 = my1; my1 = e.d;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexp_out", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("y", int'(out_data), e.d);
                chk("sat", int'(sat_flag), e.s);
                chk("lat", cyc - e.c, 7);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) chk("ready_to", 0, 1);
    endtask

    task automatic send(input int x, input logic fl);
        wait_ready();
        in_valid = 1'b1;
        in_data  = DW'(x);
        flush    = fl;
        model_push(x);
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        chk("drain", q.size(), 0);
        step();
    endtask

    task automatic cfg(input int a, input int v);
        wait_ready();
        cfg_we   = 1'b1;
        cfg_addr = 3'(a);
        cfg_data = CW'(v);
        if (a < 5) mc[a] = v;
        step();
        cfg_we = 1'b0;
        chk("cfg_ok", int'(cfg_err), 0);
    endtask

    task automatic do_flush();
        wait_ready();
        flush = 1'b1;
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
        step();
        flush = 1'b0;
    endtask

    task automatic stream(input int x, input int cnt);
        int last = -1;
        int low = 0;
        int k = 0;
        int c = 0;
        in_valid = 1'b1;
        in_data  = DW'(x);
        while (k < cnt && c < 60) begin
            if (in_ready) begin
                model_push(x);
                if (last >= 0) begin
                    chk("hs_gap", c - last, 7);
                    chk("rdy_low", low, 6);
                end
                last = c;
                low = 0;
                k++;
            end else begin
                low++;
            end
            step();
            c++;
        end
        in_valid = 1'b0;
        chk("stream_cnt", k, cnt);
    endtask

    initial begin
        in_valid = 1'b0; in_data = '0; flush = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        model_reset();
        rst_n = 1'b1;
        #23;
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_od", int'(out_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        step();
        chk("rst_rdy", int'(in_ready), 1);
        chk("rst_sat", int'(sat_flag), 0);
        chk("rst_cerr", int'(cfg_err), 0);

        // impulse with default coefficients: 100, 187, 253
        send(100, 1'b0);
        chk("busy", int'(busy), 1);
        send(0, 1'b0);
        send(0, 1'b0);
        drain();

        // flush in idle, then zero input gives zero
        do_flush();
        send(0, 1'b0);
        drain();
        // flush alongside handshake keeps history
        send(100, 1'b0);
        send(0, 1'b1);
        drain();

        // back-to-back stream
        do_flush();
        stream(50, 4);
        drain();

        // config write while busy is dropped
        send(500, 1'b0);
        step();
        step();
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = CW'(2000);
        step();
        cfg_we = 1'b0;
        chk("cfg_err_busy", int'(cfg_err), 1);
        cfg_we = 1'b1; cfg_addr = 3'd5;
        step();
        cfg_we = 1'b0;
        chk("cfg_err_pulse", int'(cfg_err), 0);
        step();
        chk("cfg_err_a5", int'(cfg_err), 0);
        drain();
        cfg(0, 512);
        send(200, 1'b0);
        drain();

        // saturation both ways
        cfg(0, 2047);
        cfg(3, 0);
        cfg(4, 0);
        do_flush();
        send(2047, 1'b0);
        drain();
        send(-2048, 1'b0);
        drain();

        // reset mid-MAC aborts the sample
        send(300, 1'b0);
        step();
        rst_n = 1'b1;
        q.delete();
        model_reset();
        #3;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ov", int'(out_valid), 0);
        step();
        rst_n = 1'b0;
        chk("mid_rst_rdy", int'(in_ready), 1);
        repeat (10) step();
        send(100, 1'b0);
        send(0, 1'b0);
        send(0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=1 exp=0");
        $fatal(1);
    end

endmodule

// File: doc/iir_mac_sched.md
Name: iir_mac_sched

Overview:
- Time-multiplexed scheduler for one second-order IIR section (zeros plus poles).
- Computes y[n] = sat((b0·x[n] + b1·x[n-1] + b2·x[n-2] + a1·y[n-1] + a2·y[n-2] + 2^(FRAC-1)) >>> FRAC).
- One shared signed multiplier is sequenced over the five taps, one product per cycle, instead of one multiplier per tap.
- Sits between the ADC sample stream and the downstream filter output.
- Holds the coefficient register file and the x/y history, with a config write port.

Parameters:
DW, 12, sample width (input and output, signed)
CW, 12, coefficient width (signed, Q(CW-FRAC-1).FRAC)
FRAC, 10, coefficient fraction bits (1024 = 1.0)
AW, 28, accumulator width (must be ≥ DW+CW+3)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high (asserted = 1)
in_valid  in  1  input sample valid
in_data  in  DW  signed input sample x[n]
in_ready  out  1  high when block can accept a sample
out_valid  out  1  one-cycle pulse, out_data valid
out_data  out  DW  signed filtered sample y[n]
sat_flag  out  1  one-cycle pulse with out_valid when y[n] was clamped
busy  out  1  high while a sample is being processed
flush  in  1  synchronous clear of x/y history, honoured only in IDLE
cfg_we  in  1  coefficient write strobe
cfg_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5–7 ignored
cfg_data  in  CW  signed coefficient value
cfg_err  out  1  one-cycle pulse when a write is dropped

Behaviour:
- Reset (rst_n=1, async) clears:
  - state → IDLE;
  - acc, x1, x2, y1, y2, out_data → 0;
  - out_valid, sat_flag, cfg_err, busy → 0;
  - in_ready → 1 after release.
- Reset coefficients: b0=1024, b1=0, b2=0, a1=1911, a2=-986.
- Feedback sign is carried in the a-coefficients: products are always added, never subtracted.
- States: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1, busy=0.
  - Handshake in_valid & in_ready captures in_data into x0, clears acc, sets tap=0, goes to MAC.
  - flush=1 with no handshake in the same cycle clears x1, x2, y1, y2.
  - If flush and a handshake coincide, the handshake wins and flush is ignored.
- MAC (5 cycles, tap 0..4):
  - Multiplier operands are (b0,x0), (b1,x1), (b2,x2), (a1,y1), (a2,y2) in that order.
  - Each cycle, acc ← acc + sign-extended product; tap increments.
  - After tap 4, go to OUT.
  - in_ready=0, busy=1.
- OUT (1 cycle):
  - r = (acc + 2^(FRAC-1)) >>> FRAC (arithmetic shift).
  - If r > 2^(DW-1)-1, clamp to 2^(DW-1)-1; if r < -2^(DW-1), clamp to -2^(DW-1); sat_flag=1 on clamp.
  - Register out_data, out_valid=1.
  - History update: x2←x1, x1←x0, y2←y1, y1←clamped y.
  - Return to IDLE.
- Latency and throughput:
  - Handshake on edge E0 gives out_valid high in the cycle after edge E6 (7 clocks).
  - Maximum throughput is one sample per 7 cycles.
  - out_valid coincides with in_ready=1, so the next sample may be accepted in that same cycle.
- No output backpressure: out_valid is a single-cycle pulse; out_data holds until the next OUT.
- Config writes:
  - Accepted only in IDLE with no handshake in that cycle; the coefficient updates on the next edge.
  - A write in MAC/OUT, or coincident with a handshake, is dropped with cfg_err=1 for one cycle.
  - Addresses 5–7 are silently ignored (no cfg_err).
- Accumulator wrap cannot occur for AW ≥ DW+CW+3.
- Reset mid-MAC aborts the sample, produces no out_valid, and clears history; coefficients return to defaults.

Test Plan:
1. Reset, default coefficients, impulse x=100 then 0, 0 → y = 100, 187, 253 on successive out_valid pulses; sat_flag=0.
2. Latency/throughput: hold in_valid=1 with a constant stream → handshakes exactly every 7 cycles; out_valid 7 cycles after each handshake; in_ready low for 6 cycles between.
3. Saturation: write b0=2047, a1=0, a2=0, flush, then x=2047 → out_data=2047, sat_flag=1. Then x=-2048 with b0=2047 and b1=0, b2=0 → out_data=-2048, sat_flag=1.
4. Config during busy: cfg_we to addr 0 in MAC cycle 3 → cfg_err pulse, b0 unchanged. The same write in IDLE → accepted, visible on the next sample.
5. Flush: after the impulse of test 1, pulse flush in IDLE, then x=0 → y=0; flush concurrent with handshake → history retained.
6. Async reset asserted mid-MAC (tap 2) → out_valid never pulses, in_ready=1 after release, next impulse x=100 reproduces 100, 187, 253.
